// File: rtl/score_bcd_display_if.sv
// score_bcd_display_if: value/start request and BCD/7-segment result bundle for score_bcd_display.
interface score_bcd_display_if;
  logic [13:0] i_value;
  logic        i_start;
  logic        o_busy;
  logic        o_done;
  logic        o_over;
  logic [15:0] o_bcd;
  logic [6:0]  o_hex3, o_hex2, o_hex1, o_hex0;
  modport master (output i_value, i_start,
                  input  o_busy, o_done, o_over, o_bcd, o_hex3, o_hex2, o_hex1, o_hex0);
  modport slave  (input  i_value, i_start,
                  output o_busy, o_done, o_over, o_bcd, o_hex3, o_hex2, o_hex1, o_hex0);
endinterface

// File: rtl/score_bcd_display.sv
// score_bcd_display: double-dabble 14-bit ms value to 4 BCD digits and 7-segment drive.
// Optional AUTO_REFRESH_EN: restart conversion whenever the input differs from the last captured value.
module score_bcd_display #(
  parameter bit BLANK_LEADING = 1'b1,
  parameter bit SEG_ACT_LOW   = 1'b1
) (
  input  logic                iCLK,
  input  logic                iRST_N,
  score_bcd_display_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [6:0] BLANK = SEG_ACT_LOW ? 7'h7F : 7'h00;
  state_t      r_state;
  logic [1:0]  r_sync;
  logic        w_rst_n;
  logic [13:0] r_bin;
  logic [15:0] r_acc;
  logic [15:0] w_adj;
  logic [3:0]  r_cnt;
  logic        w_go;
  logic [27:0] w_hex;
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'h3F;
      4'd1: seg7 = 7'h06;
      4'd2: seg7 = 7'h5B;
      4'd3: seg7 = 7'h4F;
      4'd4: seg7 = 7'h66;
      4'd5: seg7 = 7'h6D;
      4'd6: seg7 = 7'h7D;
      4'd7: seg7 = 7'h07;
      4'd8: seg7 = 7'h7F;
      4'd9: seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction
  // reset asserts immediately, releases two clocks later in step with iCLK
  always_ff @(posedge iCLK or negedge iRST_N)
    if (!iRST_N) r_sync <= 2'b00;
    else         r_sync <= {r_sync[0], 1'b1};
  assign w_rst_n = r_sync[1];
`ifdef AUTO_REFRESH_EN
  // raw input is kept so an out-of-range value does not retrigger endlessly
  logic [13:0] r_last;
  always_ff @(posedge iCLK or negedge w_rst_n)
    if (!w_rst_n)                    r_last <= '0;
    else if (r_state == IDLE && w_go) r_last <= bus.i_value;
  assign w_go = bus.i_start || (bus.i_value != r_last);
`else
  assign w_go = bus.i_start;
`endif
  for (genvar g = 0; g < 4; g++) begin : g_dig
    logic       w_blk;
    logic [6:0] w_seg;
    assign w_adj[4*g +: 4] = (r_acc[4*g +: 4] >= 4'd5) ? r_acc[4*g +: 4] + 4'd3 : r_acc[4*g +: 4];
    assign w_blk = BLANK_LEADING && (g != 0) && (r_acc[15:4*g] == '0);
    assign w_seg = seg7(r_acc[4*g +: 4]);
    assign w_hex[7*g +: 7] = w_blk ? BLANK : (SEG_ACT_LOW ? ~w_seg : w_seg);
  end
  always_ff @(posedge iCLK or negedge w_rst_n)
    if (!w_rst_n) begin
      r_state    <= IDLE;
      r_bin      <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      bus.o_busy <= 1'b0;
      bus.o_done <= 1'b0;
      bus.o_over <= 1'b0;
      bus.o_bcd  <= '0;
      bus.o_hex3 <= BLANK;
      bus.o_hex2 <= BLANK;
      bus.o_hex1 <= BLANK;
      bus.o_hex0 <= BLANK;
    end else begin
      bus.o_done <= 1'b0;
      case (r_state)
        IDLE: if (w_go) begin
          r_bin      <= (bus.i_value > 14'd9999) ? 14'd9999 : bus.i_value;
          r_acc      <= '0;
          r_cnt      <= '0;
          bus.o_busy <= 1'b1;
          bus.o_over <= bus.i_value > 14'd9999;
          r_state    <= SHIFT;
        end
        SHIFT: begin
          {r_acc, r_bin} <= {w_adj[14:0], r_bin, 1'b0};
          r_cnt          <= r_cnt + 4'd1;
          if (r_cnt == 4'd13) r_state <= DONE;
        end
        DONE: begin
          bus.o_bcd  <= r_acc;
          {bus.o_hex3, bus.o_hex2, bus.o_hex1, bus.o_hex0} <= w_hex;
          bus.o_done <= 1'b1;
          bus.o_busy <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_score_bcd_display.sv
// tb_score_bcd_display: directed checks of latency, BCD/segment output, blanking, clamp, reset abort.
module tb_score_bcd_display;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  score_bcd_display_if if0 ();
  score_bcd_display_if if1 ();
  score_bcd_display u0 (.iCLK(clk), .iRST_N(rst_n), .bus(if0.slave));
  score_bcd_display #(.BLANK_LEADING(1'b0), .SEG_ACT_LOW(1'b0)) u1 (.iCLK(clk), .iRST_N(rst_n), .bus(if1.slave));
  int n_run = 0;
  int n_fail = 0;
  logic [27:0] h0, h1;
  assign h0 = {if0.o_hex3, if0.o_hex2, if0.o_hex1, if0.o_hex0};
  assign h1 = {if1.o_hex3, if1.o_hex2, if1.o_hex1, if1.o_hex0};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic [13:0] v, input logic s);
    if0.i_value = v; if1.i_value = v;
    if0.i_start = s; if1.i_start = s;
  endtask
  task automatic run(input logic [13:0] v, output int lat, output int bc);
    @(negedge clk); drive(v, 1'b1);
    @(negedge clk); drive(v, 1'b0);
    lat = 0;
    bc  = int'(if0.o_busy);
    for (int i = 0; i < 40 && !if0.o_done; i++) begin
      @(negedge clk);
      lat++;
      if (if0.o_busy) bc++;
    end
  endtask
  task automatic count_done(input int cycles, inout int nd);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (if0.o_done) nd++;
    end
  endtask
  initial begin
    int lat, bc, nd, first;
    drive(14'd0, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(if0.o_busy), 0);
    chk("rst_done", 32'(if0.o_done), 0);
    chk("rst_over", 32'(if0.o_over), 0);
    chk("rst_bcd", 32'(if0.o_bcd), 0);
    chk("rst_hex_al", 32'(h0), 32'h0FFFFFFF);
    chk("rst_hex_ah", 32'(h1), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    run(14'd1234, lat, bc);
    chk("t1_latency", lat, 15);
    chk("t1_busy_cycles", bc, 15);
    chk("t1_bcd", 32'(if0.o_bcd), 32'h1234);
    chk("t1_hex_al", 32'(h0), 32'({7'h79, 7'h24, 7'h30, 7'h19}));
    chk("t1_hex_ah", 32'(h1), 32'({7'h06, 7'h5B, 7'h4F, 7'h66}));
    chk("t1_bcd_u1", 32'(if1.o_bcd), 32'h1234);
    @(negedge clk);
    chk("t1_done_pulse", 32'(if0.o_done), 0);
    run(14'd0, lat, bc);
    chk("t2_bcd", 32'(if0.o_bcd), 0);
    chk("t2_hex_blank", 32'(h0), 32'({7'h7F, 7'h7F, 7'h7F, 7'h40}));
    chk("t2_hex_noblank", 32'(h1), 32'({7'h3F, 7'h3F, 7'h3F, 7'h3F}));
    run(14'd12000, lat, bc);
    chk("t3_over", 32'(if0.o_over), 1);
    chk("t3_bcd", 32'(if0.o_bcd), 32'h9999);
    chk("t3_hex_al", 32'(h0), 32'({7'h10, 7'h10, 7'h10, 7'h10}));
    chk("t3_hex_ah", 32'(h1), 32'({7'h6F, 7'h6F, 7'h6F, 7'h6F}));
    run(14'd9999, lat, bc);
    chk("t3_over_clr", 32'(if0.o_over), 0);
    chk("t3_bcd_9999", 32'(if0.o_bcd), 32'h9999);
    @(negedge clk); drive(14'd305, 1'b1);
    @(negedge clk); drive(14'd305, 1'b0);
    nd = 0; first = 0;
    for (int c = 2; c <= 30; c++) begin
      @(negedge clk);
      if (c == 5) drive(14'd42, 1'b1);
      if (c == 6) drive(14'd305, 1'b0);
      if (if0.o_done) begin nd++; first = c - 1; end
    end
    chk("t4_done_count", nd, 1);
    chk("t4_latency", first, 15);
    chk("t4_bcd", 32'(if0.o_bcd), 32'h0305);
    chk("t4_hex_al", 32'(h0), 32'({7'h7F, 7'h30, 7'h40, 7'h12}));
    chk("t4_hex_ah", 32'(h1), 32'({7'h3F, 7'h4F, 7'h3F, 7'h6D}));
    @(negedge clk); drive(14'd1234, 1'b1);
    @(negedge clk); drive(14'd1234, 1'b0);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    drive(14'd0, 1'b0);
    #1;
    chk("t5_busy", 32'(if0.o_busy), 0);
    chk("t5_bcd", 32'(if0.o_bcd), 0);
    chk("t5_hex_al", 32'(h0), 32'h0FFFFFFF);
    chk("t5_hex_ah", 32'(h1), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    count_done(25, nd);
    chk("t5_no_done", nd, 0);
    run(14'd4321, lat, bc);
    chk("t5_latency", lat, 15);
    chk("t5_bcd_after", 32'(if0.o_bcd), 32'h4321);
    @(negedge clk);
    rst_n = 1'b0;
    drive(14'd0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    nd = 0;
    drive(14'd0, 1'b0); count_done(25, nd);
    drive(14'd1, 1'b0); count_done(25, nd);
    drive(14'd1, 1'b0); count_done(25, nd);
    drive(14'd2, 1'b0); count_done(25, nd);
`ifdef AUTO_REFRESH_EN
    chk("t6_auto_count", nd, 2);
    chk("t6_auto_bcd", 32'(if0.o_bcd), 32'h0002);
`else
    chk("t6_manual_count", nd, 0);
    chk("t6_manual_bcd", 32'(if0.o_bcd), 0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
